// File: rtl/dense_pipeline_sequencer.sv
// dense_pipeline_sequencer: schedules the maxpool/flatten -> dense 1600->128 ->
// dense 128->10 chain on a CPU command, then serves single-word CPU reads from
// the final-stage result BRAM.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   cmd_start/cmd_abort  one-cycle CPU command pulses (abort wins when both set)
//   stage_resetn         synchronous active-low reset to all stages
//   stage_start          one-hot, one-cycle start pulse per stage
//   stage_done           sticky per-stage completion levels
//   busy/done/error      run status
//   cur_stage            index of the stage being started or waited on
//   cpu_rd_*             CPU read request/response (DONE state only)
//   res_addr/res_data    result BRAM read port (data one cycle after address)
module dense_pipeline_sequencer #(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  output logic                  stage_resetn,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            cur_stage,
  output logic                  cpu_rd_ready,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_W-1:0]     cpu_rd_addr,
  output logic                  cpu_rd_valid,
  output logic [31:0]           cpu_rd_data,
  output logic [ADDR_W-1:0]     res_addr,
  input  logic [31:0]           res_data
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned STAGE_W = 8;
  localparam int unsigned DATA_W  = 32;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST1,
    S_RST2,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STAGE_W-1:0]     cur_stage_q, cur_stage_d;
  logic                   stage_resetn_q, stage_resetn_d;
  logic [NUM_STAGES-1:0]  stage_start_q, stage_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   rd_ready_q, rd_ready_d;
  logic                   rd_inflight_q, rd_inflight_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]      res_addr_q, res_addr_d;

  logic                   abort_take;
  logic                   done_sel;
  logic                   rd_accept;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cur_stage_q    <= '0;
      stage_resetn_q <= 1'b0;
      stage_start_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      rd_ready_q     <= 1'b0;
      rd_inflight_q  <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      res_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cur_stage_q    <= cur_stage_d;
      stage_resetn_q <= stage_resetn_d;
      stage_start_q  <= stage_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      rd_ready_q     <= rd_ready_d;
      rd_inflight_q  <= rd_inflight_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      res_addr_q     <= res_addr_d;
    end
  end

  // Next-state, timeout counter, read arbitration and next output values.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cur_stage_d    = cur_stage_q;
    stage_resetn_d = 1'b1;
    stage_start_d  = '0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    error_d        = 1'b0;
    rd_ready_d     = 1'b0;
    rd_inflight_d  = 1'b0;
    rd_valid_d     = 1'b0;
    rd_data_d      = rd_data_q;
    res_addr_d     = res_addr_q;
    abort_take     = 1'b0;
    done_sel       = 1'b0;
    rd_accept      = 1'b0;

    // Only the done level of the stage currently waited on matters.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_stage_q == STAGE_W'(i)) done_sel = stage_done[i];
    end

    if (cmd_abort) begin
      // Abort outranks a coincident start; in IDLE both are simply dropped.
      if (state_q != S_IDLE) begin
        state_d    = S_IDLE;
        abort_take = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (cmd_start) begin
            state_d     = S_RST1;
            cur_stage_d = '0;
          end
        end
        S_RST1:  state_d = S_RST2;
        S_RST2:  state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (done_sel) begin
            if (cur_stage_q == LAST_STAGE) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_START;
              cur_stage_d = cur_stage_q + STAGE_W'(1);
            end
          end else if (cnt_q >= CNT_LAST) begin
            state_d = S_ERROR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Counter reads 0 in the START cycle, so it equals cycles since the pulse.
    if (state_d == S_START) begin
      cnt_d = '0;
    end else if ((state_q == S_START || state_q == S_WAIT) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    stage_resetn_d = !(abort_take || state_d == S_RST1 || state_d == S_RST2);
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_start_d[i] = (state_d == S_START) && (cur_stage_d == STAGE_W'(i));
    end
    busy_d  = (state_d == S_RST1) || (state_d == S_RST2) ||
              (state_d == S_START) || (state_d == S_WAIT);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);

    // Reads are accepted only while DONE persists; leaving DONE drops any in flight.
    rd_accept     = cpu_rd_req && rd_ready_q && (state_q == S_DONE) && (state_d == S_DONE);
    rd_inflight_d = rd_accept;
    rd_valid_d    = rd_inflight_q && (state_d == S_DONE);
    rd_ready_d    = (state_d == S_DONE) && !rd_accept && !rd_inflight_q;
    if (rd_accept) res_addr_d = cpu_rd_addr;
    if (rd_valid_q) rd_data_d = res_data;
  end

  assign stage_resetn = stage_resetn_q;
  assign stage_start  = stage_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cur_stage    = cur_stage_q;
  assign cpu_rd_ready = rd_ready_q;
  assign cpu_rd_valid = rd_valid_q;
  assign res_addr     = res_addr_q;

  // BRAM word arrives in the valid cycle itself: forward it, hold the last word otherwise.
  assign cpu_rd_data  = rd_valid_q ? res_data : rd_data_q;

endmodule

// File: tb/tb_dense_pipeline_sequencer.sv
// tb_dense_pipeline_sequencer: directed bench for dense_pipeline_sequencer with
// sticky-done stage models and a result BRAM returning address x 3.
module tb_dense_pipeline_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic          stage_resetn;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic          busy;
  logic          done;
  logic          error;
  logic [7:0]    cur_stage;
  logic          cpu_rd_ready;
  logic          cpu_rd_req = 1'b0;
  logic [AW-1:0] cpu_rd_addr = '0;
  logic          cpu_rd_valid;
  logic [31:0]   cpu_rd_data;
  logic [AW-1:0] res_addr;
  logic [31:0]   res_data = '0;

  logic [NS-1:0] sdone = '0;
  logic [NS-1:0] early = '0;
  logic [NS-1:0] armed = '0;
  int            due [NS];
  int            dly [NS];
  int            cyc = 0;

  int            start_log[$];
  int            srst_log[$];
  int            valid_log[$];
  int            exp_q[$];

  int            n_checks = 0;
  int            n_errors = 0;

  assign stage_done = sdone | early;

  dense_pipeline_sequencer #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(64),
    .ADDR_W        (AW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .stage_resetn(stage_resetn),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cur_stage   (cur_stage),
    .cpu_rd_ready(cpu_rd_ready),
    .cpu_rd_req  (cpu_rd_req),
    .cpu_rd_addr (cpu_rd_addr),
    .cpu_rd_valid(cpu_rd_valid),
    .cpu_rd_data (cpu_rd_data),
    .res_addr    (res_addr),
    .res_data    (res_data)
  );

  always #5 clk = ~clk;

  // Cycle counter plus stage models: done rises dly cycles after the start pulse
  // (dly 0 = never) and is cleared by stage_resetn.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NS; k++) begin
      if (!stage_resetn) begin
        sdone[k] <= 1'b0;
        armed[k] <= 1'b0;
      end else if (stage_start[k]) begin
        armed[k] <= (dly[k] != 0);
        due[k]   <= cyc + dly[k];
      end else if (armed[k] && (cyc + 1 == due[k])) begin
        sdone[k] <= 1'b1;
        armed[k] <= 1'b0;
      end
    end
  end

  // Result BRAM: registered read, data = address x 3.
  always @(posedge clk) res_data <= res_addr * 32'd3;

  // Event logs keyed by the cycle number in which the output was seen.
  always @(posedge clk) begin
    if (stage_start != '0) start_log.push_back(cyc * 8 + int'(stage_start));
    if (stage_resetn === 1'b0) srst_log.push_back(cyc);
    if (cpu_rd_valid) valid_log.push_back(cyc * 1000 + int'(cpu_rd_data));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_log(input string tag, input int got[$], input int exp[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check(tag, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    start_log.delete();
    srst_log.delete();
    valid_log.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stage_resetn"}, 32'(stage_resetn), 32'd0);
    check({tag, "_stage_start"}, 32'(stage_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cur_stage"}, 32'(cur_stage), 32'd0);
    check({tag, "_rd_ready"}, 32'(cpu_rd_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(cpu_rd_valid), 32'd0);
    check({tag, "_rd_data"}, cpu_rd_data, 32'd0);
    check({tag, "_res_addr"}, res_addr, 32'd0);
  endtask

  initial begin
    dly[0] = 5; dly[1] = 20; dly[2] = 7;
    due[0] = 0; due[1] = 0; due[2] = 0;

    // Power-on reset.
    go_to(2);
    check_reset_values("por");
    go_to(3);
    resetn = 1'b1;
    go_to(6);
    check("por_release_stage_resetn", 32'(stage_resetn), 32'd1);
    check("por_release_busy", 32'(busy), 32'd0);
    clear_logs();

    // Nominal run with guard stimuli during stage 0 WAIT.
    go_to(10); cmd_start = 1'b1;
    go_to(11); cmd_start = 1'b0;
    check("nom_busy_11", 32'(busy), 32'd1);
    check("nom_cur_stage_11", 32'(cur_stage), 32'd0);
    go_to(14); cpu_rd_req = 1'b1; cpu_rd_addr = 32'd5;
    go_to(15); cmd_start = 1'b1; early = 3'b100;
    go_to(16); cmd_start = 1'b0;
    go_to(17); early = 3'b000;
    go_to(18); cpu_rd_req = 1'b0;
    go_to(20);
    check("nom_cur_stage_20", 32'(cur_stage), 32'd1);
    go_to(47);
    check("nom_done_47", 32'(done), 32'd0);
    check("nom_busy_47", 32'(busy), 32'd1);
    go_to(48);
    check("nom_done_48", 32'(done), 32'd1);
    check("nom_busy_48", 32'(busy), 32'd0);
    check("nom_error_48", 32'(error), 32'd0);
    check("nom_cur_stage_48", 32'(cur_stage), 32'd2);
    check("nom_rd_ready_48", 32'(cpu_rd_ready), 32'd1);

    // Single read then back-to-back reads.
    go_to(50); cpu_rd_req = 1'b1; cpu_rd_addr = 32'd9;
    check("rd_ready_R", 32'(cpu_rd_ready), 32'd1);
    go_to(51); cpu_rd_req = 1'b0;
    check("rd_ready_R1", 32'(cpu_rd_ready), 32'd0);
    check("rd_res_addr_R1", res_addr, 32'd9);
    go_to(52);
    check("rd_valid_R2", 32'(cpu_rd_valid), 32'd1);
    check("rd_data_R2", cpu_rd_data, 32'd27);
    check("rd_ready_R2", 32'(cpu_rd_ready), 32'd0);
    go_to(53); cpu_rd_req = 1'b1; cpu_rd_addr = 32'd100;
    check("rd_ready_R3", 32'(cpu_rd_ready), 32'd1);
    check("rd_valid_R3", 32'(cpu_rd_valid), 32'd0);
    go_to(56); cpu_rd_addr = 32'd7;
    go_to(57); cpu_rd_req = 1'b0;
    go_to(59);
    exp_q = '{13*8+1, 19*8+2, 40*8+4};
    check_log("nom_starts", start_log, exp_q);
    exp_q = '{11, 12};
    check_log("nom_stage_resetn_low", srst_log, exp_q);
    exp_q = '{52027, 55300, 58021};
    check_log("rd_valid_pulses", valid_log, exp_q);
    clear_logs();

    // Read in flight cancelled by a new run; stage 1 then times out.
    dly[1] = 0;
    go_to(60); cpu_rd_req = 1'b1; cpu_rd_addr = 32'd4;
    go_to(61); cpu_rd_req = 1'b0; cmd_start = 1'b1;
    go_to(62); cmd_start = 1'b0;
    check("to_done_cleared", 32'(done), 32'd0);
    check("to_busy_62", 32'(busy), 32'd1);
    check("to_res_addr_62", res_addr, 32'd4);
    go_to(133);
    check("to_error_133", 32'(error), 32'd0);
    check("to_busy_133", 32'(busy), 32'd1);
    go_to(134);
    check("to_error_134", 32'(error), 32'd1);
    check("to_busy_134", 32'(busy), 32'd0);
    check("to_done_134", 32'(done), 32'd0);
    check("to_cur_stage_134", 32'(cur_stage), 32'd1);
    go_to(139);
    exp_q = '{64*8+1, 70*8+2};
    check_log("to_starts", start_log, exp_q);
    exp_q = '{62, 63};
    check_log("to_stage_resetn_low", srst_log, exp_q);
    exp_q = {};
    check_log("to_cancelled_read", valid_log, exp_q);
    clear_logs();

    // Retry from ERROR, then abort+start together in stage 0 WAIT.
    dly[1] = 20;
    go_to(140); cmd_start = 1'b1;
    go_to(141); cmd_start = 1'b0;
    check("retry_error_cleared", 32'(error), 32'd0);
    check("retry_busy", 32'(busy), 32'd1);
    go_to(145); cmd_abort = 1'b1; cmd_start = 1'b1;
    go_to(146); cmd_abort = 1'b0; cmd_start = 1'b0;
    check("abort_stage_resetn_146", 32'(stage_resetn), 32'd0);
    check("abort_busy_146", 32'(busy), 32'd0);
    check("abort_error_146", 32'(error), 32'd0);
    go_to(147);
    check("abort_stage_resetn_147", 32'(stage_resetn), 32'd1);
    check("abort_busy_147", 32'(busy), 32'd0);
    go_to(169);
    exp_q = '{143*8+1};
    check_log("abort_starts", start_log, exp_q);
    exp_q = '{141, 142, 146};
    check_log("abort_stage_resetn_low", srst_log, exp_q);
    clear_logs();

    // Reset for one cycle during stage 1 WAIT, then a fresh nominal run.
    go_to(170); cmd_start = 1'b1;
    go_to(171); cmd_start = 1'b0;
    go_to(185); resetn = 1'b0;
    go_to(186); resetn = 1'b1;
    check_reset_values("midrst");
    go_to(187);
    check("midrst_stage_resetn_after", 32'(stage_resetn), 32'd1);
    go_to(190); cmd_start = 1'b1;
    go_to(191); cmd_start = 1'b0;
    go_to(227);
    check("rerun_done_227", 32'(done), 32'd0);
    go_to(228);
    check("rerun_done_228", 32'(done), 32'd1);
    check("rerun_busy_228", 32'(busy), 32'd0);
    go_to(240);
    exp_q = '{173*8+1, 179*8+2, 193*8+1, 199*8+2, 220*8+4};
    check_log("rerun_starts", start_log, exp_q);
    exp_q = '{171, 172, 186, 191, 192};
    check_log("rerun_stage_resetn_low", srst_log, exp_q);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
